mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-ported line memory between the core's I-cache read port and its D-cache
//  read/write ports. It sits between core and memory in soc, replacing their direct connection.
//  - Accepts one transaction at a time, issues it to memory and waits for completion.
//  - Routes the response back to the originating port.
//  - Fixed priority with a starvation guard so instruction fetch always progresses.
// PARAMETERS
//  WORD_SIZE     `WORD_SIZE        address width / bits
//  LINE_SIZE     `CACHE_LINE_SIZE  data line width / bits
//  STARVE_LIMIT  4                 consecutive D grants with I pending before I is forced first
// PORTS
//  clk         in   1          clock, rising edge
//  rst         in   1          asynchronous reset, active-low
//  i_read      in   1          I read request (level, held until i_res)
//  i_addr      in   WORD_SIZE  I read address
//  i_res       out  1          I response pulse
//  i_res_data  out  LINE_SIZE  I response line
//  i_res_addr  out  WORD_SIZE  I response address
//  d_read      in   1          D read request (level, held until d_res)
//  d_addr      in   WORD_SIZE  D read address
//  d_res       out  1          D read response pulse
//  d_res_data  out  LINE_SIZE  D response line
//  d_res_addr  out  WORD_SIZE  D response address
//  d_wenable   in   1          D write request (level, held until d_w_ack)
//  d_w_data    in   LINE_SIZE  D write line
//  d_w_addr    in   WORD_SIZE  D write address
//  d_w_ack     out  1          D write completion pulse
//  m_req       out  1          memory request pulse
//  m_we        out  1          1 = write, 0 = read; valid with m_req
//  m_addr      out  WORD_SIZE  memory address, held IDLE->RESP
//  m_wdata     out  LINE_SIZE  memory write line, held IDLE->RESP
//  m_res       in   1          memory completion pulse (reads and writes)
//  m_rdata     in   LINE_SIZE  read line, valid with m_res
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, starve_cnt=0. All outputs are 0, including data and address.
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   IDLE: if any request is high, latch winner source, addr and wdata, then go to ISSUE.
//         Otherwise stay in IDLE. m_res received in IDLE is ignored.
//   ISSUE: m_req=1 and m_we=(source==DW) for exactly 1 cycle, then go to WAIT.
//   WAIT: hold until m_res=1. Capture m_rdata, then go to RESP.
//         m_res is accepted in WAIT only, never in ISSUE.
//   RESP: 1-cycle pulse on exactly one of i_res / d_res / d_w_ack, then go to IDLE.
//         *_res_addr returns the latched address. *_res_data returns the captured line.
//         Both hold until the next RESP on that port (write responses leave data outputs unchanged).
//  Priority in IDLE: d_wenable > d_read > i_read.
//   Exception: if i_read && starve_cnt>=STARVE_LIMIT, I wins.
//  starve_cnt: +1 on each D grant while i_read is high (saturating at STARVE_LIMIT).
//   Cleared on an I grant, and cleared in IDLE when i_read=0.
//  Latency: request first high in IDLE cycle T -> m_req in T+1.
//   m_res in cycle W -> response pulse in W+1 -> IDLE in W+2.
//   Minimum round trip: 4 cycles with a 1-cycle memory.
//  Requester rule: drop the request on the clock edge that samples its response pulse.
//   The arbiter re-samples requests only in IDLE, so a served request is never re-granted.
//  Simultaneous requests: the loser stays pending untouched and is served in a later IDLE.
//  Input changes while not in IDLE do not affect the in-flight transaction (everything is latched).
//  Reset mid-transaction: abort immediately to IDLE. No response pulse is produced for the aborted
//   transaction. A late m_res after reset is ignored.
// TESTING
//  1. Single i_read addr=0x40, memory latency 3 -> one m_req (m_we=0, m_addr=0x40);
//     i_res 1 cycle after m_res, i_res_addr=0x40, i_res_data=m_rdata.
//  2. d_wenable, d_read, i_read all high in the same cycle -> service order DW, DR, I;
//     d_w_ack, then d_res, then i_res; never two pulses in one cycle.
//  3. i_read held while D alternates write/read continuously -> I is granted after exactly
//     4 D grants; starve_cnt returns to 0.
//  4. Inputs change during WAIT (d_w_addr 0x80->0xC0) -> m_addr stays 0x80 until RESP.
//  5. rst=0 asserted during WAIT -> all outputs 0 at once; no response pulse;
//     a subsequent m_res is ignored; next i_read is served normally.
//  6. m_res pulse while IDLE with no requests -> no output pulse, state remains IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported line memory between the I-cache read port and the
// D-cache read/write ports: one transaction in flight, fixed priority with a starvation guard.
module mem_arbiter #(
  parameter int WORD_SIZE    = 32,
  parameter int LINE_SIZE    = 128,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_read_i,
  input  logic [WORD_SIZE-1:0] i_addr_i,
  output logic                 i_res_o,
  output logic [LINE_SIZE-1:0] i_res_data_o,
  output logic [WORD_SIZE-1:0] i_res_addr_o,
  input  logic                 d_read_i,
  input  logic [WORD_SIZE-1:0] d_addr_i,
  output logic                 d_res_o,
  output logic [LINE_SIZE-1:0] d_res_data_o,
  output logic [WORD_SIZE-1:0] d_res_addr_o,
  input  logic                 d_wenable_i,
  input  logic [LINE_SIZE-1:0] d_w_data_i,
  input  logic [WORD_SIZE-1:0] d_w_addr_i,
  output logic                 d_w_ack_o,
  output logic                 m_req_o,
  output logic                 m_we_o,
  output logic [WORD_SIZE-1:0] m_addr_o,
  output logic [LINE_SIZE-1:0] m_wdata_o,
  input  logic                 m_res_i,
  input  logic [LINE_SIZE-1:0] m_rdata_i
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  typedef enum logic [1:0] {
    SRC_I,
    SRC_DR,
    SRC_DW
  } src_t;

  state_t               state_q, state_d;
  src_t                 src_q, src_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [LINE_SIZE-1:0] wdata_q, wdata_d;
  logic [CW-1:0]        starve_q, starve_d;
  logic [LINE_SIZE-1:0] i_res_data_q, i_res_data_d;
  logic [WORD_SIZE-1:0] i_res_addr_q, i_res_addr_d;
  logic [LINE_SIZE-1:0] d_res_data_q, d_res_data_d;
  logic [WORD_SIZE-1:0] d_res_addr_q, d_res_addr_d;

  logic any_req;
  logic force_i;
  src_t grant;

  // Winner selection: writes beat reads, D beats I, unless I has waited too long.
  always_comb begin
    any_req = i_read_i | d_read_i | d_wenable_i;
    force_i = i_read_i && (starve_q >= LIMIT);
    grant   = SRC_I;
    if (force_i) begin
      grant = SRC_I;
    end else if (d_wenable_i) begin
      grant = SRC_DW;
    end else if (d_read_i) begin
      grant = SRC_DR;
    end
  end

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    starve_d     = starve_q;
    i_res_data_d = i_res_data_q;
    i_res_addr_d = i_res_addr_q;
    d_res_data_d = d_res_data_q;
    d_res_addr_d = d_res_addr_q;

    unique case (state_q)
      S_IDLE: begin
        if (!i_read_i) begin
          starve_d = '0;
        end
        if (any_req) begin
          src_d   = grant;
          state_d = S_ISSUE;
          wdata_d = '0;
          unique case (grant)
            SRC_DW: begin
              addr_d  = d_w_addr_i;
              wdata_d = d_w_data_i;
            end
            SRC_DR:  addr_d = d_addr_i;
            default: addr_d = i_addr_i;
          endcase
          // The counter only grows while an I fetch is actually being passed over.
          if (grant == SRC_I) begin
            starve_d = '0;
          end else if (i_read_i) begin
            starve_d = (starve_q >= LIMIT) ? LIMIT : starve_q + CW'(1);
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (m_res_i) begin
          state_d = S_RESP;
          if (src_q == SRC_I) begin
            i_res_data_d = m_rdata_i;
            i_res_addr_d = addr_q;
          end else if (src_q == SRC_DR) begin
            d_res_data_d = m_rdata_i;
            d_res_addr_d = addr_q;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      src_q        <= SRC_I;
      addr_q       <= '0;
      wdata_q      <= '0;
      starve_q     <= '0;
      i_res_data_q <= '0;
      i_res_addr_q <= '0;
      d_res_data_q <= '0;
      d_res_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      starve_q     <= starve_d;
      i_res_data_q <= i_res_data_d;
      i_res_addr_q <= i_res_addr_d;
      d_res_data_q <= d_res_data_d;
      d_res_addr_q <= d_res_addr_d;
    end
  end

  assign m_req_o      = (state_q == S_ISSUE);
  assign m_we_o       = (state_q == S_ISSUE) && (src_q == SRC_DW);
  assign m_addr_o     = addr_q;
  assign m_wdata_o    = wdata_q;
  assign i_res_o      = (state_q == S_RESP) && (src_q == SRC_I);
  assign d_res_o      = (state_q == S_RESP) && (src_q == SRC_DR);
  assign d_w_ack_o    = (state_q == S_RESP) && (src_q == SRC_DW);
  assign i_res_data_o = i_res_data_q;
  assign i_res_addr_o = i_res_addr_q;
  assign d_res_data_o = d_res_data_q;
  assign d_res_addr_o = d_res_addr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected memory requests and
// responses, independent monitors pop and compare them as the DUT produces them.
module tb_mem_arbiter;

  localparam int W = 32;
  localparam int L = 128;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_read_i = 1'b0;
  logic [W-1:0] i_addr_i = '0;
  logic         i_res_o;
  logic [L-1:0] i_res_data_o;
  logic [W-1:0] i_res_addr_o;
  logic         d_read_i = 1'b0;
  logic [W-1:0] d_addr_i = '0;
  logic         d_res_o;
  logic [L-1:0] d_res_data_o;
  logic [W-1:0] d_res_addr_o;
  logic         d_wenable_i = 1'b0;
  logic [L-1:0] d_w_data_i = '0;
  logic [W-1:0] d_w_addr_i = '0;
  logic         d_w_ack_o;
  logic         m_req_o;
  logic         m_we_o;
  logic [W-1:0] m_addr_o;
  logic [L-1:0] m_wdata_o;
  logic         m_res_i;
  logic [L-1:0] m_rdata_i;

  logic         memRes = 1'b0;
  logic         manualRes = 1'b0;
  logic [L-1:0] memData = '0;
  int           memLat = 1;

  int checks = 0;
  int errors = 0;
  int pulseCount = 0;
  int mreqCount = 0;
  int pulsesNow;
  int kindAct;

  typedef struct {
    int           kind;
    logic [W-1:0] addr;
  } resp_t;

  typedef struct {
    logic         we;
    logic [W-1:0] addr;
    logic [L-1:0] wdata;
  } mreq_t;

  resp_t respQ[$];
  mreq_t memQ[$];
  resp_t er;
  mreq_t em;

  assign m_res_i   = memRes | manualRes;
  assign m_rdata_i = memData;

  always #5 clk = ~clk;

  mem_arbiter #(.WORD_SIZE(W), .LINE_SIZE(L), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read_i(i_read_i), .i_addr_i(i_addr_i), .i_res_o(i_res_o),
    .i_res_data_o(i_res_data_o), .i_res_addr_o(i_res_addr_o),
    .d_read_i(d_read_i), .d_addr_i(d_addr_i), .d_res_o(d_res_o),
    .d_res_data_o(d_res_data_o), .d_res_addr_o(d_res_addr_o),
    .d_wenable_i(d_wenable_i), .d_w_data_i(d_w_data_i), .d_w_addr_i(d_w_addr_i),
    .d_w_ack_o(d_w_ack_o),
    .m_req_o(m_req_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
    .m_res_i(m_res_i), .m_rdata_i(m_rdata_i)
  );

  function automatic logic [L-1:0] memLine(input logic [W-1:0] a);
    return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'h0000_1111};
  endfunction

  function automatic logic [L-1:0] wrLine(input logic [W-1:0] a);
    return {4{a ^ 32'hC3C3_0000}};
  endfunction

  task automatic checkOutput(input string name, input logic [L-1:0] act, input logic [L-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL timeout_%s: got no pulse expected a pulse", name);
  endtask

  task automatic expectResp(input int kind, input logic [W-1:0] a);
    resp_t r;
    r.kind = kind;
    r.addr = a;
    respQ.push_back(r);
  endtask

  task automatic expectMem(input logic we, input logic [W-1:0] a, input logic [L-1:0] wd);
    mreq_t m;
    m.we = we;
    m.addr = a;
    m.wdata = wd;
    memQ.push_back(m);
  endtask

  // Memory model: answers each request after memLat cycles with a line derived from the address.
  initial begin
    logic [W-1:0] a;
    forever begin
      @(negedge clk);
      if (m_req_o) begin
        a = m_addr_o;
        repeat (memLat) @(negedge clk);
        memData = memLine(a);
        memRes  = 1'b1;
        @(negedge clk);
        memRes  = 1'b0;
        memData = '0;
      end
    end
  end

  // Response monitor: every pulse must match the oldest expected response.
  always @(negedge clk) begin
    pulsesNow = int'(i_res_o) + int'(d_res_o) + int'(d_w_ack_o);
    if (pulsesNow > 0) begin
      pulseCount += pulsesNow;
      if (pulsesNow > 1) begin
        checkOutput("single_pulse", L'(pulsesNow), L'(1));
      end else if (respQ.size() == 0) begin
        checkOutput("unexpected_pulse", L'(pulsesNow), L'(0));
      end else begin
        er = respQ.pop_front();
        kindAct = i_res_o ? 0 : (d_res_o ? 1 : 2);
        checkOutput("resp_kind", L'(kindAct), L'(er.kind));
        if (er.kind == 0 && kindAct == 0) begin
          checkOutput("i_res_addr", L'(i_res_addr_o), L'(er.addr));
          checkOutput("i_res_data", i_res_data_o, memLine(er.addr));
        end else if (er.kind == 1 && kindAct == 1) begin
          checkOutput("d_res_addr", L'(d_res_addr_o), L'(er.addr));
          checkOutput("d_res_data", d_res_data_o, memLine(er.addr));
        end
      end
    end
  end

  // Memory-side monitor: every m_req must match the oldest expected memory access.
  always @(negedge clk) begin
    if (m_req_o) begin
      mreqCount++;
      if (memQ.size() == 0) begin
        checkOutput("unexpected_m_req", L'(1), L'(0));
      end else begin
        em = memQ.pop_front();
        checkOutput("m_we", L'(m_we_o), L'(em.we));
        checkOutput("m_addr", L'(m_addr_o), L'(em.addr));
        if (em.we) checkOutput("m_wdata", m_wdata_o, em.wdata);
      end
    end
  end

  task automatic iReq(input logic [W-1:0] a, output int cycles);
    int n;
    i_addr_i = a;
    i_read_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!i_res_o && n < 200);
    if (!i_res_o) timeoutFail("i_res");
    i_read_i = 1'b0;
    cycles = n;
  endtask

  task automatic dRead(input logic [W-1:0] a);
    int n;
    d_addr_i = a;
    d_read_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!d_res_o && n < 200);
    if (!d_res_o) timeoutFail("d_res");
    d_read_i = 1'b0;
  endtask

  task automatic dWrite(input logic [W-1:0] a);
    int n;
    d_w_addr_i  = a;
    d_w_data_i  = wrLine(a);
    d_wenable_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!d_w_ack_o && n < 200);
    if (!d_w_ack_o) timeoutFail("d_w_ack");
    d_wenable_i = 1'b0;
  endtask

  function automatic logic anyOutput();
    return |{i_res_o, i_res_data_o, i_res_addr_o, d_res_o, d_res_data_o, d_res_addr_o,
             d_w_ack_o, m_req_o, m_we_o, m_addr_o, m_wdata_o};
  endfunction

  task automatic applyStimulus(input int testId);
    int cyc;
    int n;
    int pBase;
    int mBase;
    case (testId)
      1: begin
        memLat = 3;
        expectMem(1'b0, 32'h40, '0);
        expectResp(0, 32'h40);
        iReq(32'h40, cyc);
        checkOutput("i_latency_mem3", L'(cyc), L'(5));
      end
      2: begin
        memLat = 1;
        expectMem(1'b1, 32'h200, wrLine(32'h200)); expectResp(2, 32'h200);
        expectMem(1'b0, 32'h210, '0);              expectResp(1, 32'h210);
        expectMem(1'b1, 32'h220, wrLine(32'h220)); expectResp(2, 32'h220);
        expectMem(1'b0, 32'h230, '0);              expectResp(1, 32'h230);
        expectMem(1'b0, 32'h300, '0);              expectResp(0, 32'h300);
        expectMem(1'b1, 32'h240, wrLine(32'h240)); expectResp(2, 32'h240);
        fork
          iReq(32'h300, cyc);
          begin
            dWrite(32'h200); dRead(32'h210); dWrite(32'h220); dRead(32'h230); dWrite(32'h240);
          end
        join
      end
      3: begin
        memLat = 2;
        expectMem(1'b1, 32'h400, wrLine(32'h400)); expectResp(2, 32'h400);
        expectMem(1'b0, 32'h410, '0);              expectResp(1, 32'h410);
        expectMem(1'b0, 32'h420, '0);              expectResp(0, 32'h420);
        fork
          dWrite(32'h400);
          dRead(32'h410);
          iReq(32'h420, cyc);
        join
      end
      4: begin
        memLat = 4;
        expectMem(1'b1, 32'h80, wrLine(32'h80));
        expectResp(2, 32'h80);
        fork
          dWrite(32'h80);
          begin
            n = 0;
            do begin
              @(negedge clk);
              n++;
            end while (!m_req_o && n < 50);
            if (!m_req_o) timeoutFail("m_req_t4");
            d_w_addr_i = 32'hC0;
            d_w_data_i = wrLine(32'hC0);
            n = 0;
            do begin
              @(negedge clk);
              n++;
              checkOutput("m_addr_held", L'(m_addr_o), L'(32'h80));
              checkOutput("m_wdata_held", m_wdata_o, wrLine(32'h80));
            end while (!d_w_ack_o && n < 50);
          end
        join
      end
      5: begin
        memLat = 6;
        pBase = pulseCount;
        expectMem(1'b0, 32'h100, '0);
        i_addr_i = 32'h100;
        i_read_i = 1'b1;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!m_req_o && n < 50);
        if (!m_req_o) timeoutFail("m_req_t5");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("outputs_after_abort", L'(anyOutput()), L'(0));
        i_read_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("no_pulse_after_abort", L'(pulseCount - pBase), L'(0));
        memLat = 2;
        expectMem(1'b0, 32'h140, '0);
        expectResp(0, 32'h140);
        iReq(32'h140, cyc);
        checkOutput("i_latency_mem2", L'(cyc), L'(4));
      end
      6: begin
        pBase = pulseCount;
        mBase = mreqCount;
        memData = memLine(32'hDEAD_0000);
        manualRes = 1'b1;
        @(negedge clk);
        manualRes = 1'b0;
        memData = '0;
        repeat (4) @(negedge clk);
        checkOutput("idle_m_res_pulses", L'(pulseCount - pBase), L'(0));
        checkOutput("idle_m_res_mreq", L'(mreqCount - mBase), L'(0));
        memLat = 1;
        expectMem(1'b0, 32'h500, '0);
        expectResp(0, 32'h500);
        iReq(32'h500, cyc);
        checkOutput("i_latency_mem1", L'(cyc), L'(3));
      end
      default: ;
    endcase
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", L'(anyOutput()), L'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int t = 1; t <= 6; t++) begin
      applyStimulus(t);
    end
    checkOutput("resp_queue_empty", L'(respQ.size()), L'(0));
    checkOutput("mem_queue_empty", L'(memQ.size()), L'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
